// File: rtl/cache_pkg.sv
// Shared types and width helpers for the direct-mapped write-back data cache.
package cache_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COMPARE,
    ST_WB_REQ,
    ST_ALLOC_REQ,
    ST_ALLOC_WAIT
  } state_t;

  localparam int ADDR_W         = 32;
  localparam int WORD_W         = 32;
  localparam int DEF_LINE_BYTES = 16;
  localparam int DEF_NUM_SETS   = 16;

  localparam logic MEM_CMD_READ  = 1'b0;
  localparam logic MEM_CMD_WRITE = 1'b1;

  function automatic int offset_w(input int line_bytes);
    return $clog2(line_bytes);
  endfunction

  function automatic int index_w(input int num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int tag_w(input int line_bytes, input int num_sets);
    return ADDR_W - index_w(num_sets) - offset_w(line_bytes);
  endfunction

  localparam int DEF_OFFSET_W = offset_w(DEF_LINE_BYTES);
  localparam int DEF_INDEX_W  = index_w(DEF_NUM_SETS);
  localparam int DEF_TAG_W    = tag_w(DEF_LINE_BYTES, DEF_NUM_SETS);

endpackage

// File: rtl/cache_line_array.sv
// Tag/valid/dirty/data storage: asynchronous read, synchronous line fill or word write,
// asynchronous clear of the valid and dirty bits only.
module cache_line_array
  import cache_pkg::*;
#(
  parameter  int LINE_BYTES = DEF_LINE_BYTES,
  parameter  int NUM_SETS   = DEF_NUM_SETS,
  localparam int IDX_W      = index_w(NUM_SETS),
  localparam int TAG_W      = tag_w(LINE_BYTES, NUM_SETS),
  localparam int WSEL_W     = offset_w(LINE_BYTES) - 2,
  localparam int LINE_W     = LINE_BYTES * 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IDX_W-1:0]  index,
  output logic [TAG_W-1:0]  rd_tag,
  output logic              rd_valid,
  output logic              rd_dirty,
  output logic [LINE_W-1:0] rd_line,
  input  logic              fill_en,
  input  logic [TAG_W-1:0]  fill_tag,
  input  logic [LINE_W-1:0] fill_line,
  input  logic              word_en,
  input  logic [WSEL_W-1:0] word_sel,
  input  logic [WORD_W-1:0] word_data
);

  logic [NUM_SETS-1:0] valid_bits;
  logic [NUM_SETS-1:0] dirty_bits;
  logic [TAG_W-1:0]    tags  [NUM_SETS];
  logic [LINE_W-1:0]   lines [NUM_SETS];

  assign rd_tag   = tags[index];
  assign rd_valid = valid_bits[index];
  assign rd_dirty = dirty_bits[index];
  assign rd_line  = lines[index];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_bits <= '0;
      dirty_bits <= '0;
    end else if (fill_en) begin
      valid_bits[index] <= 1'b1;
      dirty_bits[index] <= 1'b0;
    end else if (word_en) begin
      dirty_bits[index] <= 1'b1;
    end
  end

  // Payload storage is never reset; validity alone decides whether it is used.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tags[index]  <= fill_tag;
      lines[index] <= fill_line;
    end else if (word_en) begin
      lines[index][word_sel*WORD_W +: WORD_W] <= word_data;
    end
  end

endmodule

// File: rtl/data_cache.sv
// Write-back, write-allocate, direct-mapped data cache between the MEM stage and a
// multi-cycle line-oriented backing memory.
module data_cache
  import cache_pkg::*;
#(
  parameter  int LINE_BYTES = DEF_LINE_BYTES,
  parameter  int NUM_SETS   = DEF_NUM_SETS,
  localparam int LINE_W     = LINE_BYTES * 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              is_input_valid,
  input  logic [31:0]       addr,
  input  logic              mem_rw,
  input  logic [31:0]       din,
  output logic              is_ready,
  output logic              is_output_valid,
  output logic [31:0]       dout,
  output logic              is_hit,
  output logic              mem_req_valid,
  output logic              mem_req_write,
  output logic [31:0]       mem_req_addr,
  output logic [LINE_W-1:0] mem_req_data,
  input  logic              mem_req_ready,
  input  logic              mem_resp_valid,
  input  logic [LINE_W-1:0] mem_resp_data,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
);

  localparam int OFF_W  = offset_w(LINE_BYTES);
  localparam int IDX_W  = index_w(NUM_SETS);
  localparam int TAG_W  = tag_w(LINE_BYTES, NUM_SETS);
  localparam int WSEL_W = OFF_W - 2;

  state_t state, next_state;

  logic [31:0] req_addr;
  logic        req_rw;
  logic [31:0] req_din;
  logic        missed;

  logic [IDX_W-1:0]  req_index;
  logic [TAG_W-1:0]  req_tag;
  logic [WSEL_W-1:0] req_word;

  logic [TAG_W-1:0]  rd_tag;
  logic              rd_valid;
  logic              rd_dirty;
  logic [LINE_W-1:0] rd_line;
  logic              tag_hit;
  logic              fill_en;
  logic              word_en;

  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[1:0];

  assign req_index = req_addr[OFF_W +: IDX_W];
  assign req_tag   = req_addr[ADDR_W-1 -: TAG_W];
  assign req_word  = req_addr[2 +: WSEL_W];
  assign tag_hit   = rd_valid && (rd_tag == req_tag);

  cache_line_array #(
    .LINE_BYTES(LINE_BYTES),
    .NUM_SETS  (NUM_SETS)
  ) u_lines (
    .clk      (clk),
    .reset    (reset),
    .index    (req_index),
    .rd_tag   (rd_tag),
    .rd_valid (rd_valid),
    .rd_dirty (rd_dirty),
    .rd_line  (rd_line),
    .fill_en  (fill_en),
    .fill_tag (req_tag),
    .fill_line(mem_resp_data),
    .word_en  (word_en),
    .word_sel (req_word),
    .word_data(req_din)
  );

  // Request latch: captured once at acceptance, held until the request completes.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && is_input_valid) begin
      req_addr <= addr;
      req_rw   <= mem_rw;
      req_din  <= din;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      missed     <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      state <= next_state;
      if (state == ST_COMPARE) begin
        if (tag_hit) begin
          missed <= 1'b0;
          if (missed) miss_count <= miss_count + 32'd1;
          else        hit_count  <= hit_count + 32'd1;
        end else begin
          missed <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    next_state      = state;
    is_ready        = 1'b0;
    is_output_valid = 1'b0;
    is_hit          = 1'b0;
    dout            = '0;
    mem_req_valid   = 1'b0;
    mem_req_write   = MEM_CMD_READ;
    mem_req_addr    = '0;
    mem_req_data    = '0;
    fill_en         = 1'b0;
    word_en         = 1'b0;
    case (state)
      ST_IDLE: begin
        is_ready = 1'b1;
        if (is_input_valid) next_state = ST_COMPARE;
      end
      ST_COMPARE: begin
        if (tag_hit) begin
          is_output_valid = 1'b1;
          is_hit          = ~missed;
          dout            = req_rw ? 32'd0 : rd_line[req_word*WORD_W +: WORD_W];
          word_en         = req_rw;
          next_state      = ST_IDLE;
        end else if (rd_valid && rd_dirty) begin
          next_state = ST_WB_REQ;
        end else begin
          next_state = ST_ALLOC_REQ;
        end
      end
      ST_WB_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_write = MEM_CMD_WRITE;
        mem_req_addr  = {rd_tag, req_index, {OFF_W{1'b0}}};
        mem_req_data  = rd_line;
        if (mem_req_ready) next_state = ST_ALLOC_REQ;
      end
      ST_ALLOC_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {req_tag, req_index, {OFF_W{1'b0}}};
        if (mem_req_ready) next_state = ST_ALLOC_WAIT;
      end
      ST_ALLOC_WAIT: begin
        if (mem_resp_valid) begin
          fill_en    = 1'b1;
          next_state = ST_COMPARE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

endmodule

// File: doc/data_cache.md
Name: data_cache

Overview:
- Write-back, write-allocate, direct-mapped data cache between the pipeline MEM stage and a multi-cycle backing data memory.
- Takes one word load/store at a time from the MEM stage and lowers is_ready while servicing a miss, so the pipeline stalls.
- Exchanges whole lines with memory through a valid/ready request channel and a valid-only response channel.

Parameters:
- LINE_BYTES, 16, bytes per line; power of two ≥ 8.
- NUM_SETS, 16, number of lines; power of two.
- Address field widths are derived: offset = log2(LINE_BYTES), index = log2(NUM_SETS), tag = 32 − index − offset.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- is_input_valid  in  1  CPU request present.
- addr  in  32  byte address; addr[1:0] ignored.
- mem_rw  in  1  0 = load, 1 = store.
- din  in  32  store word.
- is_ready  out  1  cache can accept a request.
- is_output_valid  out  1  request complete this cycle.
- dout  out  32  load word; valid with is_output_valid.
- is_hit  out  1  completed request hit on first lookup; valid with is_output_valid.
- mem_req_valid  out  1  memory request present.
- mem_req_write  out  1  1 = line write, 0 = line read.
- mem_req_addr  out  32  line-aligned address.
- mem_req_data  out  LINE_BYTES*8  write line data.
- mem_req_ready  in  1  memory accepts the request this cycle.
- mem_resp_valid  in  1  read line returned.
- mem_resp_data  in  LINE_BYTES*8  returned line.
- hit_count  out  32  completed hits.
- miss_count  out  32  completed misses.

Behaviour:
- States:
  - IDLE: is_ready = 1.
  - COMPARE: look up the latched request.
  - WB_REQ: write back the dirty victim.
  - ALLOC_REQ: request the new line.
  - ALLOC_WAIT: wait for the returned line.
- Reset (asynchronous; also mid-operation):
  - State goes to IDLE; all valid and dirty bits cleared; missed flag cleared; counters = 0.
  - In-flight memory transaction abandoned; outputs 0 except is_ready = 1.
  - Data and tag arrays are not cleared.
- Accept:
  - In IDLE with is_input_valid = 1, latch addr, mem_rw and din; go to COMPARE.
  - is_input_valid is ignored outside IDLE.
  - Inputs are not re-sampled after acceptance.
- COMPARE, hit (valid && tag match):
  - is_output_valid = 1 combinationally this cycle.
  - Load: dout = selected word.
  - Store: write din into the word at the next edge and set dirty.
  - is_hit = ~missed.
  - At the edge, increment hit_count if !missed, else miss_count; clear missed; go to IDLE.
  - Best-case latency: accept at edge N, output during cycle N+1.
- COMPARE, miss:
  - Set missed.
  - Victim valid && dirty: go to WB_REQ. Otherwise: go to ALLOC_REQ.
- WB_REQ:
  - mem_req_valid = 1, mem_req_write = 1.
  - mem_req_addr = {victim tag, index, 0}; mem_req_data = victim line.
  - Held stable until mem_req_ready; then go to ALLOC_REQ.
  - Writes get no response.
- ALLOC_REQ:
  - mem_req_valid = 1, mem_req_write = 0, mem_req_addr = {req tag, index, 0}.
  - Held until mem_req_ready; then go to ALLOC_WAIT.
  - mem_req_ready in the same cycle as mem_req_valid counts as a handshake.
- ALLOC_WAIT:
  - On mem_resp_valid, write the line, set tag, valid = 1, dirty = 0; go to COMPARE. The re-compare hits.
  - mem_resp_valid in any other state is ignored.
- Counters wrap at 2^32. Exactly one counter increments per completed request.

Decomposition:
- cache_pkg:
  - State enum.
  - Offset/index/tag width localparams derived from the parameters.
  - Mem-request command constants.
- One sub-module, cache_line_array: tag/valid/dirty/data storage.
  - Asynchronous read.
  - Synchronous write: full-line fill or single-word write.
  - Asynchronous clear of valid/dirty.
- The FSM, request latch and counters stay in data_cache.

Test Plan:
- Cold load of addr 0x100 after reset; memory returns line with word 0 = 0xDEADBEEF after 3 cycles.
  → ALLOC_REQ to 0x100, no WB_REQ; is_output_valid with dout = 0xDEADBEEF, is_hit = 0; miss_count = 1.
- Load 0x104 immediately after.
  → is_output_valid one cycle after acceptance, is_hit = 1, dout = word 1 of the returned line; hit_count = 1.
- Store 0x12345678 to 0x108 (hit), then load 0x208 (same index, different tag).
  → WB_REQ at 0x100 whose data has word 2 = 0x12345678, then ALLOC_REQ at 0x200; is_hit = 0.
- Hold mem_req_ready low 5 cycles during WB_REQ.
  → mem_req_valid, addr and data stable all 5 cycles; is_ready = 0 throughout; exactly one write issued.
- Assert reset during ALLOC_WAIT, then load 0x104.
  → Outputs clear immediately; the old response is ignored; the 0x104 load misses (valid bits cleared).
- Pulse is_input_valid with 0x300 during a miss on 0x100.
  → Ignored; only the 0x100 request completes; miss_count increments once.
